// File: rtl/count_scheduler.sv
// Shared 4-bit counter arbitrated among four requesters; each owner runs a count to its own terminal value.
// Latency: grant one edge after req in IDLE; a run takes len+1 enabled RUN cycles, then one DONE cycle.
// Backpressure: enable low pauses an active run; dropping the owner's req aborts it without a done pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req[3:0]     per-requester run request, held until done or aborted
//   len[15:0]    len[4i+3:4i] = terminal count of requester i, sampled at grant
//   enable       count enable for the active run
//   grant[3:0]   one-hot owner of the counter, 0 when idle
//   owner[1:0]   index of the current or last owner
//   busy         high whenever not IDLE
//   counter_out  shared counter value
//   done[3:0]    one-cycle completion pulse for the owner
//
// Build option: define COUNT_SCHED_ROUND_ROBIN_EN for round-robin arbitration
// (search upward from a rotating pointer); otherwise lowest index wins and no
// pointer exists.
module count_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] len,
  input  logic        enable,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [3:0]  counter_out,
  output logic [3:0]  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  done_q, done_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  win;

`ifdef COUNT_SCHED_ROUND_ROBIN_EN
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  idx;
  logic        found;

  // First requester at or above the pointer, wrapping modulo 4.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    len_d   = len_q;
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 4'd0) begin
          state_d = RUN;
          grant_d = 4'b0001 << win;
          owner_d = win;
          cnt_d   = 4'd0;
          len_d   = len[{win, 2'b00} +: 4];
        end
      end
      RUN: begin
        // Abort wins over enable: owner withdrew, counter keeps its value.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = 4'd0;
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
          ptr_d   = owner_q + 2'd1;
`endif
        end else if (enable) begin
          if (cnt_q == len_q) begin
            // Terminal reached: counter holds, so 15 never wraps to 0.
            state_d = DONE;
            done_d  = grant_q;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 4'd0;
        done_d  = 4'd0;
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
        ptr_d   = owner_q + 2'd1;
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'd0;
        done_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'd0;
      owner_q <= 2'd0;
      cnt_q   <= 4'd0;
      done_q  <= 4'd0;
      len_q   <= 4'd0;
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      len_q   <= len_d;
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign counter_out = cnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_count_scheduler.sv
// Bench for count_scheduler: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_count_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic        enable;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  counter_out;
  logic [3:0]  done;

  count_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .len         (len),
    .enable      (enable),
    .grant       (grant),
    .owner       (owner),
    .busy        (busy),
    .counter_out (counter_out),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  // Reference model: one active "job" (owner, target, progress) or none.
  bit        m_active;    // a job holds the counter
  bit        m_finishing; // job completed, in its done cycle
  int        m_owner;
  int        m_target;
  int        m_count;
  int        m_next;      // round-robin search start

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_finishing = 0; m_owner = 0; m_target = 0; m_count = 0; m_next = 0;
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (m_finishing) begin
      m_finishing = 0;
      m_active    = 0;
      m_next      = (m_owner + 1) % 4;
    end else if (m_active) begin
      if (!req[m_owner]) begin
        m_active = 0;
        m_next   = (m_owner + 1) % 4;
      end else if (enable) begin
        if (m_count == m_target) m_finishing = 1;
        else m_count = m_count + 1;
      end
    end else if (req != 4'd0) begin
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
      m_owner = pick(req, m_next);
`else
      m_owner = pick(req, 0);
`endif
      m_target = int'((len >> (4 * m_owner)) & 16'hF);
      m_count  = 0;
      m_active = 1;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    logic [3:0] ed;
    eg = m_active ? 4'(1 << m_owner) : 4'd0;
    ed = m_finishing ? 4'(1 << m_owner) : 4'd0;
    chk({phase, ".grant"},   16'(grant),       16'(eg));
    chk({phase, ".owner"},   16'(owner),       16'(m_owner));
    chk({phase, ".busy"},    16'(busy),        16'(m_active));
    chk({phase, ".counter"}, 16'(counter_out), 16'(m_count));
    chk({phase, ".done"},    16'(done),        16'(ed));
    chk({phase, ".onehot"},  16'($onehot0(grant) && $onehot0(done)), 16'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk({phase, ".rst_zero"}, {grant, owner, busy, counter_out, done, 1'b0}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int en_cycles;
    int max_cnt;
    bit seen;
    reset  = 1'b1;
    req    = 4'd0;
    len    = 16'd0;
    enable = 1'b0;

    phase = "reset";
    do_reset();
    cycle();
    cycle();

    // Basic run: requester 0, terminal 3.
    phase = "run0";
    req = 4'b0001; len = 16'h0003; enable = 1'b1;
    cycle();
    chk("run0.grant_first", 16'(grant), 16'h1);
    chk("run0.cnt0", 16'(counter_out), 16'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("run0.cnt_step", 16'(counter_out), 16'(i));
    end
    cycle();
    chk("run0.done_pulse", 16'(done), 16'h1);
    chk("run0.cnt_hold", 16'(counter_out), 16'd3);
    req = 4'd0;
    cycle();
    chk("run0.idle_grant", 16'(grant), 16'd0);
    chk("run0.idle_done", 16'(done), 16'd0);

    // Zero-length run on requester 2; other nibbles are nonzero.
    phase = "len0";
    req = 4'b0100; len = 16'hA0B7;
    cycle();
    chk("len0.grant", 16'(grant), 16'h4);
    chk("len0.owner", 16'(owner), 16'd2);
    cycle();
    chk("len0.done", 16'(done), 16'h4);
    chk("len0.cnt", 16'(counter_out), 16'd0);
    req = 4'd0;
    cycle();

    // Max length with enable toggling every cycle.
    phase = "len15";
    req = 4'b0001; len = 16'h000F; enable = 1'b1;
    cycle();
    len = 16'h0002; // must not affect the active run
    en_cycles = 0; max_cnt = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      enable = ~enable;
      if (enable) en_cycles++;
      cycle();
      if (int'(counter_out) > max_cnt) max_cnt = int'(counter_out);
      if (done != 4'd0) seen = 1;
    end
    chk("len15.done_seen", 16'(seen), 16'd1);
    chk("len15.enabled_cycles", 16'(en_cycles), 16'd16);
    chk("len15.max_cnt", 16'(max_cnt), 16'd15);
    req = 4'd0; enable = 1'b1;
    cycle();

    // All requesters, all length 1: grant order.
    phase = "arb";
    do_reset();
    req = 4'b1111; len = 16'h1111; enable = 1'b1;
    for (int r = 0; r < 5; r++) begin
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cycle();
        if (grant != 4'd0) seen = 1;
      end
      chk("arb.granted", 16'(seen), 16'd1);
`ifdef COUNT_SCHED_ROUND_ROBIN_EN
      chk("arb.owner_order", 16'(owner), 16'(r % 4));
`else
      chk("arb.owner_order", 16'(owner), 16'd0);
`endif
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cycle();
        if (done != 4'd0) seen = 1;
      end
      chk("arb.done_seen", 16'(seen), 16'd1);
    end
    req = 4'd0;
    cycle();
    cycle();

    // Abort at counter 2.
    phase = "abort";
    req = 4'b0010; len = 16'h0090; enable = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("abort.cnt_before", 16'(counter_out), 16'd2);
    req = 4'd0;
    cycle();
    chk("abort.grant", 16'(grant), 16'd0);
    chk("abort.busy", 16'(busy), 16'd0);
    chk("abort.done", 16'(done), 16'd0);
    chk("abort.cnt_held", 16'(counter_out), 16'd2);

    // Reset in the middle of a run.
    phase = "midrst";
    req = 4'b1000; len = 16'h5000;
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst.outputs_zero", {grant, owner, busy, counter_out, done, 1'b0}, 16'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    req = 4'd0;
    cycle();

    // Randomized traffic.
    phase = "rand";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) len = 16'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
